// File: rtl/hbm_pkg.sv
// Shared widths and FSM encoding for the HBM request arbiter.
package hbm_pkg;

  localparam int unsigned HBM_ADDR_W = 32;
  localparam int unsigned HBM_DATA_W = 512;
  localparam int unsigned HBM_TMR_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting port after last_grant_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 any_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan NUM_PORTS candidates starting just after the previous winner.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = IDX_W'((32'(last_grant_i) + i) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        grant_idx_o    = cand;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/hbm_req_arbiter.sv
// Round-robin arbiter sharing one hbm_controller among NUM_PORTS requesters,
// one outstanding transaction at a time, with a WAIT timeout.
module hbm_req_arbiter
  import hbm_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = HBM_ADDR_W,
  parameter int unsigned DATA_W    = HBM_DATA_W,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned PORT_W   = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic                        rsp_valid,
  output logic [PORT_W-1:0]           rsp_port,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_error,
  output logic [ADDR_W-1:0]           hbm_addr,
  output logic [DATA_W-1:0]           hbm_data_in,
  output logic                        hbm_wr_en,
  output logic                        hbm_rd_en,
  input  logic [DATA_W-1:0]           hbm_data_out,
  input  logic                        hbm_ready,
  input  logic                        hbm_error
);

  localparam logic [HBM_TMR_W-1:0] TIMEOUT_V = HBM_TMR_W'(TIMEOUT);

  arb_state_e           state_q, state_d;
  logic [PORT_W-1:0]    last_grant_q, last_grant_d;
  logic [PORT_W-1:0]    port_q, port_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic [HBM_TMR_W-1:0] timer_q, timer_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [PORT_W-1:0]    rsp_port_q, rsp_port_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_error_q, rsp_error_d;

  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    grant_idx;
  logic                 any_req;
  logic                 accept;
  logic [HBM_TMR_W-1:0] timer_inc;
  logic                 tmo;
  logic                 wait_done;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (PORT_W)
  ) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .any_o        (any_req)
  );

  // Grant is offered combinationally in IDLE and suppressed while reset is held.
  assign req_ready = (state_q == ST_IDLE && reset_n) ? grant : '0;
  assign accept    = (state_q == ST_IDLE) && any_req;
  assign timer_inc = timer_q + HBM_TMR_W'(1);
  assign tmo       = (timer_inc == TIMEOUT_V);
  assign wait_done = hbm_error || hbm_ready || tmo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (wait_done) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values for the request latch, controller strobes, timer and response.
  always_comb begin
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    timer_d      = timer_q;
    rsp_valid_d  = 1'b0;
    rsp_port_d   = rsp_port_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_error_d  = rsp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          port_d  = grant_idx;
          we_d    = req_we[grant_idx];
          addr_d  = req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[32'(grant_idx)*DATA_W +: DATA_W];
          wr_en_d = req_we[grant_idx];
          rd_en_d = !req_we[grant_idx];
        end
      end
      ST_ISSUE: timer_d = '0;
      ST_WAIT: begin
        timer_d = timer_inc;
        if (wait_done) begin
          // Error outranks ready; a bare timeout also reports an error.
          rsp_valid_d = 1'b1;
          rsp_port_d  = port_q;
          rsp_error_d = hbm_error || !hbm_ready;
          rsp_rdata_d = (hbm_ready && !hbm_error && !we_q) ? hbm_data_out : '0;
        end
      end
      ST_RESP: last_grant_d = port_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= PORT_W'(NUM_PORTS - 1);
      port_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      timer_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_port_q   <= '0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      timer_q      <= timer_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_port_q   <= rsp_port_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign hbm_addr    = addr_q;
  assign hbm_data_in = wdata_q;
  assign hbm_wr_en   = wr_en_q;
  assign hbm_rd_en   = rd_en_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_port    = rsp_port_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;

endmodule

// File: tb/tb_hbm_req_arbiter.sv
// Self-checking bench for hbm_req_arbiter: directed table, hand sequences, random vs. transaction model.
module tb_hbm_req_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int TMO = 8;

  localparam int K_READY = 0;
  localparam int K_ERROR = 1;
  localparam int K_BOTH  = 2;
  localparam int K_TMO   = 3;

  logic             clk;
  logic             reset_n;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_ready;
  logic [NP-1:0]    req_we;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic             rsp_valid;
  logic [1:0]       rsp_port;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_error;
  logic [AW-1:0]    hbm_addr;
  logic [DW-1:0]    hbm_data_in;
  logic             hbm_wr_en;
  logic             hbm_rd_en;
  logic [DW-1:0]    hbm_data_out;
  logic             hbm_ready;
  logic             hbm_error;

  hbm_req_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_port     (rsp_port),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .hbm_addr     (hbm_addr),
    .hbm_data_in  (hbm_data_in),
    .hbm_wr_en    (hbm_wr_en),
    .hbm_rd_en    (hbm_rd_en),
    .hbm_data_out (hbm_data_out),
    .hbm_ready    (hbm_ready),
    .hbm_error    (hbm_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  vmask;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          kind;
    int          dly;
    logic [63:0] dout;
    int          exp_port;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_last;
  logic [31:0] p_addr  [NP];
  logic [63:0] p_wdata [NP];
  logic        p_we    [NP];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_ports(input logic [3:0] vmask);
    req_valid = vmask;
    for (int p = 0; p < NP; p++) begin
      req_we[p]              = p_we[p];
      req_addr[p*AW +: AW]   = p_addr[p];
      req_wdata[p*DW +: DW]  = p_wdata[p];
    end
  endtask

  // One full transaction; entered just after a rising edge with the DUT idle.
  task automatic do_txn(input logic [3:0] vmask, input bit keep, input int kind, input int dly,
                        input logic [63:0] dout, input bit noise, input int ep,
                        input logic [31:0] e_addr, input logic [63:0] e_wdata, input logic e_we,
                        input logic [63:0] e_rdata, input logic e_err, input int e_lat);
    bit         found;
    bit         got;
    int         pulses;
    logic [3:0] oh;
    drive_ports(vmask);
    oh = '0;
    oh[ep] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("grant", 64'(req_ready), 64'(oh));
    if (!found) return;
    @(posedge clk); #1;
    if (!keep) req_valid[ep] = 1'b0;
    got = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      hbm_ready    = (c == 0 && noise) || ((kind == K_READY || kind == K_BOTH) && c == dly + 1);
      hbm_error    = (kind == K_ERROR || kind == K_BOTH) && c == dly + 1;
      hbm_data_out = (c == dly + 1) ? dout : {$urandom, $urandom};
      @(negedge clk);
      if (c == 0) begin
        chk("issue_wr_en", 64'(hbm_wr_en), 64'(e_we));
        chk("issue_rd_en", 64'(hbm_rd_en), 64'(!e_we));
        chk("issue_addr", 64'(hbm_addr), 64'(e_addr));
        chk("issue_wdata", hbm_data_in, e_wdata);
        chk("busy_ready", 64'(req_ready), 64'(0));
      end else begin
        pulses += int'(hbm_wr_en) + int'(hbm_rd_en);
      end
      if (rsp_valid) begin
        got = 1'b1;
        chk("rsp_latency", 64'(c), 64'(e_lat));
        chk("rsp_port", 64'(rsp_port), 64'(ep));
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_error", 64'(rsp_error), 64'(e_err));
        chk("hold_addr", 64'(hbm_addr), 64'(e_addr));
      end
      @(posedge clk); #1;
    end
    hbm_ready = 1'b0;
    hbm_error = 1'b0;
    chk("extra_strobe", 64'(pulses), 64'(0));
    chk("rsp_seen", 64'(got), 64'(1));
    #1;
    chk("rsp_one_cycle", 64'(rsp_valid), 64'(0));
    chk("rsp_hold_rdata", rsp_rdata, e_rdata);
    m_last = ep;
  endtask

  // Transaction-level model of the round-robin choice.
  function automatic int rr_pick(input int last, input logic [3:0] vmask);
    for (int i = 1; i <= NP; i++) begin
      if (vmask[(last + i) % NP]) return (last + i) % NP;
    end
    return -1;
  endfunction

  vec_t tbl[8];

  initial begin
    tbl[0] = '{4'b0001, 1'b1, 32'h10, 64'hDEADBEEF, K_READY, 1, 64'h0, 0, 64'h0, 1'b0, 3};
    tbl[1] = '{4'b0100, 1'b0, 32'h10, 64'h0, K_READY, 0, 64'hDEADBEEF, 2, 64'hDEADBEEF, 1'b0, 2};
    tbl[2] = '{4'b0010, 1'b0, 32'h2000, 64'h0, K_TMO, 0, 64'hFFFF, 1, 64'h0, 1'b1, TMO + 1};
    tbl[3] = '{4'b1000, 1'b0, 32'h3000, 64'h0, K_BOTH, 2, 64'h1234, 3, 64'h0, 1'b1, 4};
    tbl[4] = '{4'b0011, 1'b1, 32'h4000, 64'h77, K_ERROR, 0, 64'h5, 0, 64'h0, 1'b1, 2};
    tbl[5] = '{4'b1111, 1'b1, 32'h5000, 64'h99, K_READY, 0, 64'hABCD, 1, 64'h0, 1'b0, 2};
    tbl[6] = '{4'b1001, 1'b0, 32'h6000, 64'h0, K_READY, 5, 64'hCAFEF00D12345678, 3,
               64'hCAFEF00D12345678, 1'b0, 7};
    tbl[7] = '{4'b0110, 1'b0, 32'h7000, 64'h0, K_READY, 7, 64'h55, 1, 64'h55, 1'b0, 9};

    reset_n      = 1'b0;
    req_valid    = '0;
    req_we       = '0;
    req_addr     = '0;
    req_wdata    = '0;
    hbm_data_out = '0;
    hbm_ready    = 1'b0;
    hbm_error    = 1'b0;
    m_last       = NP - 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_wr_en", 64'(hbm_wr_en), 64'(0));
    chk("reset_rd_en", 64'(hbm_rd_en), 64'(0));
    chk("reset_addr", 64'(hbm_addr), 64'(0));
    chk("reset_rdata", rsp_rdata, 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // All ports requesting back to back: strict rotation starting at port 0.
    for (int p = 0; p < NP; p++) begin
      p_we[p]    = 1'b1;
      p_addr[p]  = 32'h1000 + 32'(p);
      p_wdata[p] = 64'hA0 + 64'(p);
    end
    for (int k = 0; k < 5; k++) begin
      do_txn(4'b1111, 1'b1, K_READY, 0, 64'h0, 1'b0, k % NP, 32'h1000 + 32'(k % NP),
             64'hA0 + 64'(k % NP), 1'b1, 64'h0, 1'b0, 2);
    end

    // Directed table; losing ports carry decoy addr/data/we.
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < NP; p++) begin
        p_we[p]    = (p == tbl[i].exp_port) ? tbl[i].we : !tbl[i].we;
        p_addr[p]  = (p == tbl[i].exp_port) ? tbl[i].addr : (tbl[i].addr ^ 32'hFFFF0000);
        p_wdata[p] = (p == tbl[i].exp_port) ? tbl[i].wdata : ~tbl[i].wdata;
      end
      do_txn(tbl[i].vmask, 1'b0, tbl[i].kind, tbl[i].dly, tbl[i].dout, bit'(i % 2),
             tbl[i].exp_port, tbl[i].addr, tbl[i].wdata, tbl[i].we,
             tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat);
      req_valid = '0;
    end

    // Controller strobes while idle must be ignored.
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      hbm_ready = (c < 3);
      hbm_error = (c < 3);
      @(negedge clk);
      chk("idle_no_rsp", 64'(rsp_valid), 64'(0));
      @(posedge clk); #1;
    end
    hbm_ready = 1'b0;
    hbm_error = 1'b0;

    // Reset during WAIT aborts the read; port 1 then wins from the reset pointer.
    p_we[1] = 1'b1;  p_addr[1] = 32'h111; p_wdata[1] = 64'h1111;
    p_we[2] = 1'b0;  p_addr[2] = 32'hABC; p_wdata[2] = 64'h2222;
    p_we[0] = 1'b0;  p_addr[0] = 32'h0;   p_wdata[0] = 64'h0;
    p_we[3] = 1'b0;  p_addr[3] = 32'h0;   p_wdata[3] = 64'h0;
    drive_ports(4'b0100);
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        @(negedge clk);
        if (|(req_valid & req_ready)) found = 1'b1;
        else begin @(posedge clk); #1; end
      end
      chk("abort_grant", 64'(req_ready), 64'(4'b0100));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_pre_addr", 64'(hbm_addr), 64'(32'hABC));
    drive_ports(4'b0110);
    reset_n = 1'b0;
    #1;
    chk("abort_addr", 64'(hbm_addr), 64'(0));
    chk("abort_data_in", hbm_data_in, 64'(0));
    chk("abort_rd_en", 64'(hbm_rd_en), 64'(0));
    chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("abort_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_last = NP - 1;
    do_txn(4'b0110, 1'b0, K_READY, 1, 64'h0, 1'b0, 1, 32'h111, 64'h1111, 1'b1,
           64'h0, 1'b0, 3);
    req_valid = '0;

    // Random transactions against the transaction-level model.
    for (int n = 0; n < 80; n++) begin
      logic [3:0]  vm;
      int          kind;
      int          dly;
      int          ep;
      int          r;
      logic [63:0] dout;
      logic [63:0] e_rd;
      vm = 4'($urandom_range(1, 15));
      for (int p = 0; p < NP; p++) begin
        p_we[p]    = 1'($urandom);
        p_addr[p]  = $urandom;
        p_wdata[p] = {$urandom, $urandom};
      end
      r    = int'($urandom_range(0, 7));
      kind = (r < 5) ? K_READY : (r == 5) ? K_ERROR : (r == 6) ? K_BOTH : K_TMO;
      dly  = int'($urandom_range(0, TMO - 1));
      dout = {$urandom, $urandom};
      ep   = rr_pick(m_last, vm);
      e_rd = (kind == K_READY && !p_we[ep]) ? dout : 64'h0;
      do_txn(vm, 1'($urandom), kind, dly, dout, 1'($urandom), ep, p_addr[ep], p_wdata[ep],
             p_we[ep], e_rd, kind != K_READY, (kind == K_TMO) ? TMO + 1 : dly + 2);
      req_valid = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
